// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (unpack / multiply / normalise-round-pack), RNE rounding, DAZ inputs.
// Optional FP_MUL_STICKY_FLAGS_EN adds flags_clr / flags_sticky accumulating {invalid, overflow, underflow, inexact}.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   data1,
  input  logic [EXP_W+MAN_W:0]   data2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid,
  output logic                   inexact
`ifdef FP_MUL_STICKY_FLAGS_EN
  ,
  input  logic                   flags_clr,
  output logic [3:0]             flags_sticky
`endif
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int PW     = 2 * (MAN_W + 1);
  localparam int EW     = EXP_W + 2;
  localparam int BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX_I = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS_I);
  localparam logic signed [EW-1:0] EMAX_S    = EW'(EMAX_I);
  localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
  localparam logic [W-1:0]         QNAN      = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic w_adv;

  // ---------------------------------------------------------------- S1
  logic                   w1_s_a, w1_s_b, w1_sign;
  logic [EXP_W-1:0]       w1_e_a, w1_e_b;
  logic [MAN_W-1:0]       w1_m_a, w1_m_b;
  logic                   w1_zero_a, w1_zero_b, w1_inf_a, w1_inf_b;
  logic                   w1_nan_a, w1_nan_b, w1_snan_a, w1_snan_b;
  logic signed [EW-1:0]   w1_exp;
  logic                   w1_spec;
  logic                   w1_spec_inv;
  logic [W-1:0]           w1_spec_res;

  assign w1_s_a    = data1[W-1];
  assign w1_s_b    = data2[W-1];
  assign w1_e_a    = data1[MAN_W +: EXP_W];
  assign w1_e_b    = data2[MAN_W +: EXP_W];
  assign w1_m_a    = data1[MAN_W-1:0];
  assign w1_m_b    = data2[MAN_W-1:0];
  assign w1_sign   = w1_s_a ^ w1_s_b;

  assign w1_zero_a = (w1_e_a == '0);
  assign w1_zero_b = (w1_e_b == '0);
  assign w1_inf_a  = (w1_e_a == EXP_ONES) && (w1_m_a == '0);
  assign w1_inf_b  = (w1_e_b == EXP_ONES) && (w1_m_b == '0);
  assign w1_nan_a  = (w1_e_a == EXP_ONES) && (w1_m_a != '0);
  assign w1_nan_b  = (w1_e_b == EXP_ONES) && (w1_m_b != '0);
  assign w1_snan_a = w1_nan_a && !w1_m_a[MAN_W-1];
  assign w1_snan_b = w1_nan_b && !w1_m_b[MAN_W-1];

  assign w1_exp = $signed({2'b00, w1_e_a}) + $signed({2'b00, w1_e_b}) - BIAS_S;

  always_comb begin
    w1_spec     = 1'b0;
    w1_spec_inv = 1'b0;
    w1_spec_res = '0;
    if (w1_nan_a || w1_nan_b) begin
      w1_spec     = 1'b1;
      w1_spec_res = QNAN;
      w1_spec_inv = w1_snan_a || w1_snan_b;
    end else if ((w1_inf_a && w1_zero_b) || (w1_zero_a && w1_inf_b)) begin
      w1_spec     = 1'b1;
      w1_spec_res = QNAN;
      w1_spec_inv = 1'b1;
    end else if (w1_inf_a || w1_inf_b) begin
      w1_spec     = 1'b1;
      w1_spec_res = {w1_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w1_zero_a || w1_zero_b) begin
      // exp==0 covers subnormals too: they are flushed without a flag
      w1_spec     = 1'b1;
      w1_spec_res = {w1_sign, {(EXP_W+MAN_W){1'b0}}};
    end
  end

  logic                 r1_valid, r1_sign, r1_spec, r1_spec_inv;
  logic signed [EW-1:0] r1_exp;
  logic [MAN_W:0]       r1_man_a, r1_man_b;
  logic [W-1:0]         r1_spec_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r1_sign     <= 1'b0;
      r1_spec     <= 1'b0;
      r1_spec_inv <= 1'b0;
      r1_exp      <= '0;
      r1_man_a    <= '0;
      r1_man_b    <= '0;
      r1_spec_res <= '0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r1_sign     <= w1_sign;
      r1_spec     <= w1_spec;
      r1_spec_inv <= w1_spec_inv;
      r1_exp      <= w1_exp;
      r1_man_a    <= {1'b1, w1_m_a};
      r1_man_b    <= {1'b1, w1_m_b};
      r1_spec_res <= w1_spec_res;
    end
  end

  // ---------------------------------------------------------------- S2
  logic                 r2_valid, r2_sign, r2_spec, r2_spec_inv;
  logic signed [EW-1:0] r2_exp;
  logic [PW-1:0]        r2_prod;
  logic [W-1:0]         r2_spec_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid    <= 1'b0;
      r2_sign     <= 1'b0;
      r2_spec     <= 1'b0;
      r2_spec_inv <= 1'b0;
      r2_exp      <= '0;
      r2_prod     <= '0;
      r2_spec_res <= '0;
    end else if (w_adv) begin
      r2_valid    <= r1_valid;
      r2_sign     <= r1_sign;
      r2_spec     <= r1_spec;
      r2_spec_inv <= r1_spec_inv;
      r2_exp      <= r1_exp;
      r2_prod     <= PW'(r1_man_a) * PW'(r1_man_b);
      r2_spec_res <= r1_spec_res;
    end
  end

  // ---------------------------------------------------------------- S3
  logic                 w3_msb, w3_g, w3_r, w3_st, w3_rup, w3_carry;
  logic [PW-1:0]        w3_norm;
  logic [MAN_W:0]       w3_sig;
  logic [MAN_W+1:0]     w3_sig_rnd;
  logic [MAN_W-1:0]     w3_man;
  logic signed [EW-1:0] w3_exp;
  logic [W-1:0]         w3_res;
  logic                 w3_ovf, w3_unf, w3_inv, w3_inx;

  // product lies in [1,4): align so the leading one is always at PW-1
  assign w3_msb     = r2_prod[PW-1];
  assign w3_norm    = w3_msb ? r2_prod : {r2_prod[PW-2:0], 1'b0};
  assign w3_sig     = w3_norm[PW-1 -: MAN_W+1];
  assign w3_g       = w3_norm[PW-2-MAN_W];
  assign w3_r       = w3_norm[PW-3-MAN_W];
  assign w3_st      = |w3_norm[PW-4-MAN_W:0];
  assign w3_rup     = w3_g && (w3_r || w3_st || w3_sig[0]);
  assign w3_sig_rnd = {1'b0, w3_sig} + (MAN_W+2)'(w3_rup);
  assign w3_carry   = w3_sig_rnd[MAN_W+1];
  assign w3_man     = w3_carry ? w3_sig_rnd[MAN_W:1] : w3_sig_rnd[MAN_W-1:0];
  assign w3_exp     = r2_exp + $signed({{(EW-1){1'b0}}, w3_msb})
                             + $signed({{(EW-1){1'b0}}, w3_carry});

  always_comb begin
    w3_res = '0;
    w3_ovf = 1'b0;
    w3_unf = 1'b0;
    w3_inv = 1'b0;
    w3_inx = 1'b0;
    if (r2_spec) begin
      w3_res = r2_spec_res;
      w3_inv = r2_spec_inv;
    end else if (w3_exp >= EMAX_S) begin
      w3_res = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
      w3_ovf = 1'b1;
      w3_inx = 1'b1;
    end else if (w3_exp[EW-1] || (w3_exp == '0)) begin
      w3_res = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
      w3_unf = 1'b1;
      w3_inx = 1'b1;
    end else begin
      w3_res = {r2_sign, w3_exp[EXP_W-1:0], w3_man};
      w3_inx = w3_g || w3_r || w3_st;
    end
  end

  // ---------------------------------------------------------------- output
  assign w_adv    = !(out_valid && !out_ready);
  assign in_ready = w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else if (w_adv) begin
      out_valid <= r2_valid;
      result    <= w3_res;
      overflow  <= w3_ovf;
      underflow <= w3_unf;
      invalid   <= w3_inv;
      inexact   <= w3_inx;
    end
  end

`ifdef FP_MUL_STICKY_FLAGS_EN
  logic       w_xfer;
  logic [3:0] w_cur_flags;
  logic [3:0] r_flags_sticky;

  assign w_xfer       = out_valid && out_ready;
  assign w_cur_flags  = {invalid, overflow, underflow, inexact};
  assign flags_sticky = r_flags_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flags_sticky <= 4'b0000;
    end else if (flags_clr) begin
      // a clear coinciding with a transfer keeps only that transfer's flags
      r_flags_sticky <= w_xfer ? w_cur_flags : 4'b0000;
    end else if (w_xfer) begin
      r_flags_sticky <= r_flags_sticky | w_cur_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed self-checking bench for fp_mul_pipe (binary32 default build, sticky flags when FP_MUL_STICKY_FLAGS_EN).
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data1, data2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, underflow, invalid, inexact;
  logic [3:0]  flags;
`ifdef FP_MUL_STICKY_FLAGS_EN
  logic        flags_clr;
  logic [3:0]  flags_sticky;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign flags = {invalid, overflow, underflow, inexact};

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .invalid   (invalid),
    .inexact   (inexact)
`ifdef FP_MUL_STICKY_FLAGS_EN
    ,
    .flags_clr    (flags_clr),
    .flags_sticky (flags_sticky)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // issues one op into an empty pipe with out_ready=1; leaves its result presented on the output
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_flags);
    data1    = a;
    data2    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, ".lat2"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".result"}, 64'(result), 64'(exp_res));
    check({tag, ".flags"}, 64'(flags), 64'(exp_flags));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data1     = '0;
    data2     = '0;
`ifdef FP_MUL_STICKY_FLAGS_EN
    flags_clr = 1'b0;
`endif
    #12;
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.result",    64'(result),    64'd0);
    check("rst.flags",     64'(flags),     64'd0);
    check("rst.in_ready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    tick();

    // flags are {invalid, overflow, underflow, inexact}
    run_op("2x3",        32'h40000000, 32'h40400000, 32'h40C00000, 4'b0000);
    run_op("neg2x3",     32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000);
    run_op("1ulp_sq",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    run_op("round_up",   32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0001);
    run_op("inf_x_0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000);
    run_op("snan",       32'h7FA00000, 32'h3F800000, 32'h7FC00000, 4'b1000);
    run_op("qnan",       32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000);
    run_op("ninf_x_2",   32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
    run_op("nzero_x_2",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
    run_op("daz",        32'h00000001, 32'h40000000, 32'h00000000, 4'b0000);
    run_op("overflow",   32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_op("underflow",  32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
    tick();
    check("drain.out_valid", 64'(out_valid), 64'd0);

    // stall: four back-to-back ops with the consumer blocked
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data1 = 32'h3F800000; data2 = 32'h3F800000; tick();
    data1 = 32'h40000000; data2 = 32'h40000000; tick();
    data1 = 32'h40400000; data2 = 32'h40400000; tick();
    data1 = 32'h3FC00000; data2 = 32'h3FC00000;
    check("stall.in_ready",  64'(in_ready),  64'd0);
    check("stall.out_valid", 64'(out_valid), 64'd1);
    check("stall.result",    64'(result),    64'h3F800000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall.hold_result", 64'(result),   64'h3F800000);
      check("stall.hold_ready",  64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("release.in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("order.r1", 64'(result), 64'h40800000);
    tick();
    check("order.r2", 64'(result), 64'h41100000);
    tick();
    check("order.r3",       64'(result),    64'h40100000);
    check("order.r3_valid", 64'(out_valid), 64'd1);
    tick();
    check("order.empty", 64'(out_valid), 64'd0);

    // reset with two ops in flight
    in_valid = 1'b1;
    data1 = 32'h40000000; data2 = 32'h40400000; tick();
    data1 = 32'h3FC00000; data2 = 32'h3FC00000; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.result",    64'(result),    64'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst.no_stale", 64'(out_valid), 64'd0);
    end

`ifdef FP_MUL_STICKY_FLAGS_EN
    check("sticky.reset", 64'(flags_sticky), 64'd0);
    run_op("st_ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101);
    run_op("st_inx", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    tick();
    check("sticky.accum", 64'(flags_sticky), 64'h5);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("sticky.clr", 64'(flags_sticky), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
Name: fp_mul_pipe

Overview:
- Parametrised, 3-stage pipelined IEEE-754 binary floating-point multiplier, successor to the single-precision combinational arithmetic blocks.
- Exponent and mantissa widths are configurable; default is binary32.
- Uses a valid/ready handshake on both sides, rounds to nearest-even, and raises overflow/underflow/invalid/inexact flags per result.
- Sits in the FPU execute path between operand issue and writeback.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1 derived.
- MAN_W, 23, stored mantissa width; total width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- data1  in  W  operand A.
- data2  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  product.
- overflow  out  1  result overflowed to ±inf.
- underflow  out  1  result flushed to ±0.
- invalid  out  1  invalid operation.
- inexact  out  1  result rounded.

Behaviour:
- Reset: all stage valid bits and out_valid = 0; result and all flags = 0. Reset mid-operation discards all in-flight operations.
- Handshake:
  - An input is accepted when in_valid && in_ready. A result transfers when out_valid && out_ready.
  - in_ready = !(out_valid && !out_ready). On stall the whole pipeline freezes; no bubble compression.
  - result and flags hold stable while out_valid && !out_ready.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput 1 per cycle. Results leave in issue order.
- S1 (unpack):
  - Split sign/exp/man. Operands with exp == 0 are treated as zero (DAZ, no flag).
  - Classify each operand as zero, inf, NaN or normal. Sign = s1 ^ s2.
  - Exponent sum = e1 + e2 - BIAS, held as a signed (EXP_W+2)-bit value.
- S2 (multiply): form the 2*(MAN_W+1)-bit product of {1,man1} and {1,man2}. Carry specials through.
- S3 (normalize/round/pack):
  - If the product MSB is set, shift right 1 and increment exp.
  - Take guard, round and sticky bits; round to nearest-even. A rounding carry-out renormalises and increments exp.
  - inexact = guard|round|sticky.
  - exp ≥ 2^EXP_W-1 → ±inf, overflow=1, inexact=1.
  - exp ≤ 0 → ±0, underflow=1, inexact=1.
- Specials (priority order):
  1. Any NaN → canonical qNaN (sign 0, exp all ones, man MSB 1, rest 0); invalid=1 only if either input is a signalling NaN (man MSB 0).
  2. inf×0 → canonical qNaN, invalid=1.
  3. inf×finite or inf×inf → ±inf, no flags.
  4. zero×finite → signed zero, no flags.
- Flags apply only to the result they accompany and are not sticky.

Optional Feature:
- Macro: FP_MUL_STICKY_FLAGS_EN.
- Defined: adds input flags_clr (1 bit) and output flags_sticky (4 bits: {invalid, overflow, underflow, inexact}).
  - flags_sticky ORs in the result flags on each out_valid && out_ready.
  - flags_clr zeroes the register. If flags_clr coincides with a transfer, the register takes that transfer's flags only.
  - Reset value 0.
- Undefined: neither port exists and there is no extra state.

Test Plan:
- 0x40000000 × 0x40400000, out_ready=1 → result 0x40C00000 exactly 3 cycles later, all flags 0.
- 0x3F800001 × 0x3F800001 → 0x3F800002, inexact=1, other flags 0.
- 0x7F800000 × 0x00000000 → 0x7FC00000, invalid=1; 0x7FA00000 × 0x3F800000 → 0x7FC00000, invalid=1; 0x7FC00000 × 0x3F800000 → 0x7FC00000, invalid=0.
- 0x7F000000 × 0x7F000000 → 0x7F800000 with overflow=1, inexact=1; 0x00800000 × 0x00800000 → 0x00000000 with underflow=1, inexact=1.
- Issue 4 back-to-back ops, hold out_ready=0 for 5 cycles → in_ready drops, result held stable; on release the 4 results emerge in order at one per cycle.
- Assert rst while 2 ops are in flight → out_valid=0 and result=0 immediately; no stale result appears afterwards. With FP_MUL_STICKY_FLAGS_EN, an overflow op then an inexact op → flags_sticky=4'b0101; flags_clr → 0.
